mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 214 +++++++++++++++++++++
 tb/tb_mc_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control FSM: sequences fetch, decode, execute,
// memory and writeback for lw/sw/R-type/beq/bne/addi/j; traps illegal ops.
//
// Ports:
//   clk, reset      clock, async active-high reset
//   op, funct       instruction fields from the instruction register
//   zero            ALU zero flag
//   mem_ready       shared memory completion handshake
//   iord..alucontrol datapath control (Moore, plus mem_ready/zero gating)
//   state           current state code (debug)
//   illegal         sticky trap flag
module mc_controller #(
  parameter bit HAS_BNE = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_TRAP    = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;

  logic is_mem, is_rtype, is_br, is_addi, is_j;
  logic fn_ok, op_bne;

  assign fn_ok = (funct == FN_ADD) || (funct == FN_SUB) ||
                 (funct == FN_AND) || (funct == FN_OR)  ||
                 (funct == FN_SLT);

  assign op_bne   = (op == OP_BNE);
  assign is_mem   = (op == OP_LW) || (op == OP_SW);
  assign is_rtype = (op == OP_RTYPE) && fn_ok;
  assign is_br    = (op == OP_BEQ) || (HAS_BNE && op_bne);
  assign is_addi  = (op == OP_ADDI);
  assign is_j     = (op == OP_J);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        // op classes are disjoint, so the one-hot decode is safe
        unique case (1'b1)
          is_mem:   state_d = S_MEMADR;
          is_rtype: state_d = S_RTYPEEX;
          is_br:    state_d = S_BEQEX;
          is_addi:  state_d = S_ADDIEX;
          is_j:     state_d = S_JEX;
          default:  state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_RTYPEEX: state_d = S_RTYPEWB;
      S_RTYPEWB: state_d = S_FETCH;
      S_BEQEX:   state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JEX:     state_d = S_FETCH;
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase
  end

  logic [2:0] fn_alu;

  always_comb begin
    fn_alu = ALU_ADD;
    unique case (funct)
      FN_SUB:  fn_alu = ALU_SUB;
      FN_AND:  fn_alu = ALU_AND;
      FN_OR:   fn_alu = ALU_OR;
      FN_SLT:  fn_alu = ALU_SLT;
      default: fn_alu = ALU_ADD;
    endcase
  end

  logic pcen_c, irwrite_c, regwrite_c, memwrite_c, illegal_c;

  always_comb begin
    iord       = 1'b0;
    memwrite_c = 1'b0;
    irwrite_c  = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite_c = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    pcen_c     = 1'b0;
    alucontrol = 3'b000;
    illegal_c  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alusrcb    = 2'b01;
        alucontrol = ALU_ADD;
        irwrite_c  = mem_ready;
        pcen_c     = mem_ready;
      end
      S_DECODE: begin
        alusrcb    = 2'b11;
        alucontrol = ALU_ADD;
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_MEMRD:   iord = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_c = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite_c = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
      end
      S_RTYPEWB: begin
        regdst     = 1'b1;
        regwrite_c = 1'b1;
      end
      S_BEQEX: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        // only reachable with op=bne when HAS_BNE is set
        pcen_c     = op_bne ? ~zero : zero;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = ALU_ADD;
      end
      S_ADDIWB:  regwrite_c = 1'b1;
      S_JEX: begin
        pcsrc  = 2'b10;
        pcen_c = 1'b1;
      end
      S_TRAP:    illegal_c = 1'b1;
      default:   illegal_c = 1'b1;
    endcase
  end

  // reset masks enables combinationally, independent of the clock
  assign pcen     = pcen_c & ~reset;
  assign irwrite  = irwrite_c & ~reset;
  assign regwrite = regwrite_c & ~reset;
  assign memwrite = memwrite_c & ~reset;
  assign illegal  = illegal_c & ~reset;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized instruction-level bench for mc_controller.
// Expected per-cycle outputs come from instruction phase sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;

  typedef struct packed {
    logic [3:0] st;
    logic       iord, memwrite, irwrite, regdst;
    logic       memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic       pcen;
    logic [2:0] aluc;
    logic       ill;
  } obs_t;

  obs_t o0, o1;

  logic iord0, mw0, irw0, rd0, m2r0, rw0, asa0, pce0, il0;
  logic [1:0] asb0, pcs0;
  logic [2:0] ac0;
  logic [3:0] st0;
  logic iord1, mw1, irw1, rd1, m2r1, rw1, asa1, pce1, il1;
  logic [1:0] asb1, pcs1;
  logic [2:0] ac1;
  logic [3:0] st1;

  mc_controller #(.HAS_BNE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .iord(iord0), .memwrite(mw0), .irwrite(irw0),
    .regdst(rd0), .memtoreg(m2r0), .regwrite(rw0),
    .alusrca(asa0), .alusrcb(asb0), .pcsrc(pcs0),
    .pcen(pce0), .alucontrol(ac0), .state(st0),
    .illegal(il0)
  );

  mc_controller #(.HAS_BNE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .iord(iord1), .memwrite(mw1), .irwrite(irw1),
    .regdst(rd1), .memtoreg(m2r1), .regwrite(rw1),
    .alusrca(asa1), .alusrcb(asb1), .pcsrc(pcs1),
    .pcen(pce1), .alucontrol(ac1), .state(st1),
    .illegal(il1)
  );

  assign o0 = {st0, iord0, mw0, irw0, rd0, m2r0, rw0,
               asa0, asb0, pcs0, pce0, ac0, il0};
  assign o1 = {st1, iord1, mw1, irw1, rd1, m2r1, rw1,
               asa1, asb1, pcs1, pce1, ac1, il1};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input obs_t got,
                     input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h (st %0d vs %0d)",
               tag, got, exp, got.st, exp.st);
    end
  endtask

  // expected output vectors, one per state as listed in the spec
  function automatic obs_t e_fetch(input logic mr);
    obs_t e = '0;
    e.alusrcb = 2'b01; e.aluc = 3'b010;
    e.irwrite = mr; e.pcen = mr;
    return e;
  endfunction
  function automatic obs_t e_decode();
    obs_t e = '0;
    e.st = 4'd1; e.alusrcb = 2'b11; e.aluc = 3'b010;
    return e;
  endfunction
  function automatic obs_t e_memadr();
    obs_t e = '0;
    e.st = 4'd2; e.alusrca = 1'b1;
    e.alusrcb = 2'b10; e.aluc = 3'b010;
    return e;
  endfunction
  function automatic obs_t e_memrd();
    obs_t e = '0;
    e.st = 4'd3; e.iord = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwb();
    obs_t e = '0;
    e.st = 4'd4; e.memtoreg = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_memwr();
    obs_t e = '0;
    e.st = 4'd5; e.iord = 1'b1; e.memwrite = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_rex(input logic [2:0] a);
    obs_t e = '0;
    e.st = 4'd6; e.alusrca = 1'b1; e.aluc = a;
    return e;
  endfunction
  function automatic obs_t e_rwb();
    obs_t e = '0;
    e.st = 4'd7; e.regdst = 1'b1; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_beq(input logic p);
    obs_t e = '0;
    e.st = 4'd8; e.alusrca = 1'b1; e.aluc = 3'b110;
    e.pcsrc = 2'b01; e.pcen = p;
    return e;
  endfunction
  function automatic obs_t e_addiex();
    obs_t e = '0;
    e.st = 4'd9; e.alusrca = 1'b1;
    e.alusrcb = 2'b10; e.aluc = 3'b010;
    return e;
  endfunction
  function automatic obs_t e_addiwb();
    obs_t e = '0;
    e.st = 4'd10; e.regwrite = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_jex();
    obs_t e = '0;
    e.st = 4'd11; e.pcsrc = 2'b10; e.pcen = 1'b1;
    return e;
  endfunction
  function automatic obs_t e_trap();
    obs_t e = '0;
    e.st = 4'd12; e.ill = 1'b1;
    return e;
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] f);
    case (f)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      default:   return 3'b111;
    endcase
  endfunction

  localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_BEQ = 3;
  localparam int K_ADDI = 4, K_J = 5, K_BNE = 6, K_ILL = 7;

  // one cycle: drive inputs at negedge, check, let posedge consume
  task automatic step(input logic mr, input logic z,
                      input obs_t x0, input obs_t x1,
                      input string tag);
    @(negedge clk);
    mem_ready = mr;
    zero = z;
    #1;
    chk({tag, "_h0"}, o0, x0);
    chk({tag, "_h1"}, o1, x1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_now_h0", o0, e_fetch(1'b0));
    chk("rst_now_h1", o1, e_fetch(1'b0));
    mem_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_hold_h0", o0, e_fetch(1'b0));
    chk("rst_hold_h1", o1, e_fetch(1'b0));
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  task automatic run_instr(input int kind, input logic [5:0] opv,
                           input logic [5:0] fv, input logic z,
                           input int fst, input int mst);
    logic r;
    op = opv;
    funct = fv;
    for (int i = 0; i < fst; i++)
      step(1'b0, z, e_fetch(1'b0), e_fetch(1'b0), "fetch_stall");
    step(1'b1, z, e_fetch(1'b1), e_fetch(1'b1), "fetch");
    r = 1'($urandom_range(0, 1));
    step(r, z, e_decode(), e_decode(), "decode");
    r = 1'($urandom_range(0, 1));
    case (kind)
      K_LW: begin
        step(r, z, e_memadr(), e_memadr(), "lw_adr");
        for (int i = 0; i < mst; i++)
          step(1'b0, z, e_memrd(), e_memrd(), "lw_rd_stall");
        step(1'b1, z, e_memrd(), e_memrd(), "lw_rd");
        step(r, z, e_memwb(), e_memwb(), "lw_wb");
      end
      K_SW: begin
        step(r, z, e_memadr(), e_memadr(), "sw_adr");
        for (int i = 0; i < mst; i++)
          step(1'b0, z, e_memwr(), e_memwr(), "sw_wr_stall");
        step(1'b1, z, e_memwr(), e_memwr(), "sw_wr");
      end
      K_RT: begin
        step(r, z, e_rex(alu_of(fv)), e_rex(alu_of(fv)), "rt_ex");
        step(r, z, e_rwb(), e_rwb(), "rt_wb");
      end
      K_BEQ: step(r, z, e_beq(z), e_beq(z), "beq_ex");
      K_ADDI: begin
        step(r, z, e_addiex(), e_addiex(), "addi_ex");
        step(r, z, e_addiwb(), e_addiwb(), "addi_wb");
      end
      K_J: step(r, z, e_jex(), e_jex(), "j_ex");
      K_BNE: begin
        step(r, z, e_trap(), e_beq(~z), "bne_ex");
        do_reset();
      end
      default: begin
        for (int i = 0; i < 10; i++) begin
          r = 1'($urandom_range(0, 1));
          step(r, r ^ z, e_trap(), e_trap(), "trap");
        end
        do_reset();
      end
    endcase
  endtask

  function automatic logic legal_op(input logic [5:0] o);
    return o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
           o == 6'b000100 || o == 6'b000101 || o == 6'b001000 ||
           o == 6'b000010;
  endfunction

  initial begin
    logic [5:0] fns [5];
    logic [5:0] ro, rf;
    int k;
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100;
    fns[3] = 6'b100101; fns[4] = 6'b101010;
    reset = 1'b1;
    op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("reset_h0", o0, e_fetch(1'b0));
    chk("reset_h1", o1, e_fetch(1'b0));
    repeat (2) @(posedge clk);
    do_reset();

    // directed cases
    run_instr(K_RT, 6'b000000, 6'b100000, 1'b0, 0, 0);
    run_instr(K_LW, 6'b100011, 6'b000000, 1'b0, 0, 2);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b1, 0, 0);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b0, 0, 0);
    run_instr(K_BNE, 6'b000101, 6'b000000, 1'b0, 0, 0);
    run_instr(K_BNE, 6'b000101, 6'b000000, 1'b1, 1, 0);
    run_instr(K_ILL, 6'b000000, 6'b000000, 1'b0, 0, 0);
    run_instr(K_J, 6'b000010, 6'b000000, 1'b0, 0, 0);
    run_instr(K_SW, 6'b101011, 6'b000000, 1'b0, 1, 1);
    run_instr(K_ADDI, 6'b001000, 6'b000000, 1'b0, 0, 0);

    // sw aborted by reset while stalled in MEMWR
    op = 6'b101011;
    step(1'b1, 1'b0, e_fetch(1'b1), e_fetch(1'b1), "swr_fetch");
    step(1'b1, 1'b0, e_decode(), e_decode(), "swr_decode");
    step(1'b1, 1'b0, e_memadr(), e_memadr(), "swr_adr");
    step(1'b0, 1'b0, e_memwr(), e_memwr(), "swr_wr");
    do_reset();
    run_instr(K_RT, 6'b000000, 6'b101010, 1'b0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 7);
      rf = fns[$urandom_range(0, 4)];
      case (k)
        K_LW:   ro = 6'b100011;
        K_SW:   ro = 6'b101011;
        K_RT:   ro = 6'b000000;
        K_BEQ:  ro = 6'b000100;
        K_ADDI: ro = 6'b001000;
        K_J:    ro = 6'b000010;
        K_BNE:  ro = 6'b000101;
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            ro = 6'b000000;
            do rf = 6'($urandom);
            while (rf == fns[0] || rf == fns[1] || rf == fns[2] ||
                   rf == fns[3] || rf == fns[4]);
          end else begin
            do ro = 6'($urandom);
            while (legal_op(ro));
          end
        end
      endcase
      if (k != K_RT && k != K_ILL) rf = 6'($urandom);
      run_instr(k, ro, rf, 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
